// File: rtl/cpu_pkg.sv
// Shared constants for the 8-bit processor control path: opcodes,
// ALU select codes, sequencer state encoding and the decoder bundle.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HALT = 1'b1;

    typedef struct packed {
        logic [2:0] aluop;
        logic       wr_en;
        logic       imm_sel;
        logic       neg_sel;
        logic       illegal;
        logic       is_j;
        logic       is_beq;
    } dec_t;

endpackage

// File: rtl/cpu_control_pc_instr_decoder.sv
// Opcode decoder: pure combinational map from the opcode byte to the
// ALU select, datapath strobes and the branch/jump/illegal flags.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] opcode_i,
    output dec_t       dec_o
);

    // Anything outside 0x00..0x07 is illegal and leaves all strobes low.
    always_comb begin
        dec_o = '0;
        case (opcode_i)
            OP_LOADI: begin
                dec_o.aluop   = ALU_FWD;
                dec_o.imm_sel = 1'b1;
                dec_o.wr_en   = 1'b1;
            end
            OP_MOV: begin
                dec_o.aluop = ALU_FWD;
                dec_o.wr_en = 1'b1;
            end
            OP_ADD: begin
                dec_o.aluop = ALU_ADD;
                dec_o.wr_en = 1'b1;
            end
            OP_SUB: begin
                dec_o.aluop   = ALU_ADD;
                dec_o.neg_sel = 1'b1;
                dec_o.wr_en   = 1'b1;
            end
            OP_AND: begin
                dec_o.aluop = ALU_AND;
                dec_o.wr_en = 1'b1;
            end
            OP_OR: begin
                dec_o.aluop = ALU_OR;
                dec_o.wr_en = 1'b1;
            end
            OP_J: begin
                dec_o.aluop = ALU_FWD;
                dec_o.is_j  = 1'b1;
            end
            OP_BEQ: begin
                dec_o.aluop   = ALU_ADD;
                dec_o.neg_sel = 1'b1;
                dec_o.is_beq  = 1'b1;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/cpu_control_pc.sv
// Instruction sequencer: program counter, branch/jump target, run/halt
// state machine and retired-instruction counter.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   ST_RUN  | fetch/execute; PC advances and RETIRED counts each cycle
//   ST_HALT | illegal opcode seen; PC/RETIRED frozen until reset
module cpu_control_pc
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      INSTRUCTION,
    input  logic             ZERO,
    output logic [31:0]      PC,
    output logic [2:0]       ALUOP,
    output logic             WRITEENABLE,
    output logic             IMM_SEL,
    output logic             NEG_SEL,
    output logic             HALTED,
    output logic [CNT_W-1:0] RETIRED
);

    logic [31:0]      pc_q, pc_d;
    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    dec_t        dec;
    logic        run_en;
    logic        take_target;
    logic [31:0] pc_plus4;
    logic [31:0] offset_ext;
    logic [31:0] target;
    logic        unused_fields;

    instr_decoder u_dec (
        .opcode_i (INSTRUCTION[31:24]),
        .dec_o    (dec)
    );

    // Register operand fields are consumed by the datapath, not here.
    assign unused_fields = ^INSTRUCTION[15:0];

    assign run_en = RESET && (state_q == ST_RUN);

    assign pc_plus4    = pc_q + 32'd4;
    assign offset_ext  = {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};
    assign target      = pc_plus4 + offset_ext;
    assign take_target = dec.is_j || (dec.is_beq && ZERO);

    // Control strobes are only meaningful while running and out of reset.
    assign ALUOP       = run_en ? dec.aluop : ALU_FWD;
    assign WRITEENABLE = run_en && dec.wr_en;
    assign IMM_SEL     = run_en && dec.imm_sel;
    assign NEG_SEL     = run_en && dec.neg_sel;

    assign HALTED  = (state_q == ST_HALT);
    assign PC      = pc_q;
    assign RETIRED = retired_q;

    // Next-state: advance PC and count while running; an illegal opcode
    // freezes everything on the cycle it is seen.
    always_comb begin
        pc_d      = pc_q;
        state_d   = state_q;
        retired_d = retired_q;
        if (state_q == ST_RUN) begin
            if (dec.illegal) begin
                state_d = ST_HALT;
            end else begin
                pc_d      = take_target ? target : pc_plus4;
                retired_d = retired_q + 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            pc_q      <= RESET_PC;
            state_q   <= ST_RUN;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_cpu_control_pc.sv
// Bench for cpu_control_pc: a driver issues one instruction per cycle and
// queues the expected outputs; a monitor compares them mid-cycle.
module tb_cpu_control_pc;

    typedef struct {
        string       nm;
        int          inst;
        logic [31:0] pc;
        logic [15:0] ret;
        logic [2:0]  alu;
        logic        we;
        logic        imm;
        logic        neg;
        logic        halted;
    } exp_t;

    logic clk;

    logic        rst0, rst1, rst2;
    logic [31:0] instr0, instr1, instr2;
    logic        zero0, zero1, zero2;

    logic [31:0] pc0, pc1, pc2;
    logic [2:0]  alu0, alu1, alu2;
    logic        we0, we1, we2;
    logic        imm0, imm1, imm2;
    logic        neg0, neg1, neg2;
    logic        h0, h1, h2;
    logic [15:0] ret0, ret1;
    logic [3:0]  ret2;

    exp_t sb[$];
    exp_t e;
    int   tests;
    int   failed;

    logic [31:0] a_pc;
    logic [15:0] a_ret;
    logic [2:0]  a_alu;
    logic        a_we, a_imm, a_neg, a_h;

    localparam logic [31:0] I_ADD   = 32'h0201_0203;
    localparam logic [31:0] I_SUB   = 32'h0301_0203;
    localparam logic [31:0] I_LOADI = 32'h0001_0055;
    localparam logic [31:0] I_AND   = 32'h0401_0203;
    localparam logic [31:0] I_OR    = 32'h0501_0203;
    localparam logic [31:0] I_MOV   = 32'h0101_0200;
    localparam logic [31:0] I_BEQ2  = 32'h0702_0102;
    localparam logic [31:0] I_JFE   = 32'h06FE_0000;
    localparam logic [31:0] I_ILL   = 32'h2A00_0000;

    cpu_control_pc #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut0 (
        .CLK(clk), .RESET(rst0), .INSTRUCTION(instr0), .ZERO(zero0),
        .PC(pc0), .ALUOP(alu0), .WRITEENABLE(we0), .IMM_SEL(imm0),
        .NEG_SEL(neg0), .HALTED(h0), .RETIRED(ret0)
    );

    cpu_control_pc #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(16)) dut1 (
        .CLK(clk), .RESET(rst1), .INSTRUCTION(instr1), .ZERO(zero1),
        .PC(pc1), .ALUOP(alu1), .WRITEENABLE(we1), .IMM_SEL(imm1),
        .NEG_SEL(neg1), .HALTED(h1), .RETIRED(ret1)
    );

    cpu_control_pc #(.RESET_PC(32'h0000_0000), .CNT_W(4)) dut2 (
        .CLK(clk), .RESET(rst2), .INSTRUCTION(instr2), .ZERO(zero2),
        .PC(pc2), .ALUOP(alu2), .WRITEENABLE(we2), .IMM_SEL(imm2),
        .NEG_SEL(neg2), .HALTED(h2), .RETIRED(ret2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus on an instance and queue its expectation.
    task automatic step(input int inst, input logic rst, input logic [31:0] ins,
                        input logic z, input string nm, input logic [31:0] pc,
                        input logic [15:0] ret, input logic [2:0] alu,
                        input logic we, input logic imm, input logic neg,
                        input logic halted);
        exp_t x;
        case (inst)
            0: begin rst0 = rst; instr0 = ins; zero0 = z; end
            1: begin rst1 = rst; instr1 = ins; zero1 = z; end
            default: begin rst2 = rst; instr2 = ins; zero2 = z; end
        endcase
        x.nm = nm; x.inst = inst; x.pc = pc; x.ret = ret; x.alu = alu;
        x.we = we; x.imm = imm; x.neg = neg; x.halted = halted;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, compare the selected instance against the queue head.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.inst)
                0: begin a_pc = pc0; a_ret = ret0; a_alu = alu0; a_we = we0;
                         a_imm = imm0; a_neg = neg0; a_h = h0; end
                1: begin a_pc = pc1; a_ret = ret1; a_alu = alu1; a_we = we1;
                         a_imm = imm1; a_neg = neg1; a_h = h1; end
                default: begin a_pc = pc2; a_ret = {12'd0, ret2}; a_alu = alu2;
                         a_we = we2; a_imm = imm2; a_neg = neg2; a_h = h2; end
            endcase
            tests++;
            if (a_pc !== e.pc || a_ret !== e.ret || a_alu !== e.alu ||
                a_we !== e.we || a_imm !== e.imm || a_neg !== e.neg ||
                a_h !== e.halted) begin
                failed++;
                $display("FAIL %s: got pc=%h ret=%0d alu=%b we=%b imm=%b neg=%b halted=%b, expected pc=%h ret=%0d alu=%b we=%b imm=%b neg=%b halted=%b",
                         e.nm, a_pc, a_ret, a_alu, a_we, a_imm, a_neg, a_h,
                         e.pc, e.ret, e.alu, e.we, e.imm, e.neg, e.halted);
            end
        end
    end

    initial begin
        tests = 0;
        failed = 0;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
        instr0 = I_ADD; instr1 = I_ADD; instr2 = I_ADD;
        zero0 = 1'b0; zero1 = 1'b0; zero2 = 1'b0;
        @(posedge clk);
        #1;

        // reset hold, then straight-line decode and a taken beq
        step(0, 0, I_ADD,   0, "rst_hold1",   32'd0,  16'd0, 3'b000, 0, 0, 0, 0);
        step(0, 0, I_ADD,   0, "rst_hold2",   32'd0,  16'd0, 3'b000, 0, 0, 0, 0);
        step(0, 1, I_ADD,   0, "add_pc0",     32'd0,  16'd0, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_ADD,   0, "add_pc4",     32'd4,  16'd1, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_BEQ2,  1, "beq_taken",   32'd8,  16'd2, 3'b001, 0, 0, 1, 0);
        step(0, 1, I_SUB,   0, "sub_pc20",    32'd20, 16'd3, 3'b001, 1, 0, 1, 0);
        step(0, 1, I_LOADI, 0, "loadi_pc24",  32'd24, 16'd4, 3'b000, 1, 1, 0, 0);
        step(0, 1, I_AND,   0, "and_pc28",    32'd28, 16'd5, 3'b010, 1, 0, 0, 0);
        step(0, 1, I_OR,    0, "or_pc32",     32'd32, 16'd6, 3'b011, 1, 0, 0, 0);
        step(0, 1, I_MOV,   0, "mov_pc36",    32'd36, 16'd7, 3'b000, 1, 0, 0, 0);
        step(0, 0, I_ADD,   0, "rst_midprog", 32'd40, 16'd8, 3'b000, 0, 0, 0, 0);

        // not-taken beq, backward jump, then illegal opcode and halt
        step(0, 1, I_ADD,   0, "restart_pc0", 32'd0,  16'd0, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_ADD,   0, "add2_pc4",    32'd4,  16'd1, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_BEQ2,  0, "beq_ntaken",  32'd8,  16'd2, 3'b001, 0, 0, 1, 0);
        step(0, 1, I_ADD,   0, "add_pc12",    32'd12, 16'd3, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_JFE,   0, "j_back",      32'd16, 16'd4, 3'b000, 0, 0, 0, 0);
        step(0, 1, I_ADD,   0, "j_land_pc12", 32'd12, 16'd5, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_ADD,   0, "add_pc16",    32'd16, 16'd6, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_ADD,   0, "add_pc20",    32'd20, 16'd7, 3'b001, 1, 0, 0, 0);
        step(0, 1, I_ILL,   1, "illegal",     32'd24, 16'd8, 3'b000, 0, 0, 0, 0);
        step(0, 1, I_ILL,   0, "halt_c1",     32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 1, I_ILL,   0, "halt_c2",     32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 1, I_ILL,   0, "halt_c3",     32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 1, I_ADD,   0, "halt_c4_add", 32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 1, I_JFE,   0, "halt_c5_j",   32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 0, I_ADD,   0, "rst_in_halt", 32'd24, 16'd8, 3'b000, 0, 0, 0, 1);
        step(0, 1, I_ADD,   0, "unhalt_pc0",  32'd0,  16'd0, 3'b001, 1, 0, 0, 0);

        // reset wins over a taken branch in the same cycle
        step(0, 1, I_ADD,   0, "add3_pc4",    32'd4,  16'd1, 3'b001, 1, 0, 0, 0);
        step(0, 0, I_BEQ2,  1, "rst_vs_beq",  32'd8,  16'd2, 3'b000, 0, 0, 0, 0);
        step(0, 1, I_ADD,   0, "post_rst_pc", 32'd0,  16'd0, 3'b001, 1, 0, 0, 0);

        // PC wrap from 0xFFFF_FFFC
        step(1, 0, I_ADD,   0, "wrap_rst",    32'hFFFF_FFFC, 16'd0, 3'b000, 0, 0, 0, 0);
        step(1, 1, I_ADD,   0, "wrap_top",    32'hFFFF_FFFC, 16'd0, 3'b001, 1, 0, 0, 0);
        step(1, 1, I_ADD,   0, "wrap_zero",   32'd0, 16'd1, 3'b001, 1, 0, 0, 0);
        step(1, 1, I_ADD,   0, "wrap_four",   32'd4, 16'd2, 3'b001, 1, 0, 0, 0);

        // 4-bit retired counter wrap
        for (int i = 0; i < 18; i++) begin
            step(2, 1, I_ADD, 0, $sformatf("cnt4_%0d", i), 32'(4 * i),
                 16'(i % 16), 3'b001, 1, 0, 0, 0);
        end

        for (int k = 0; k < 5 && sb.size() > 0; k++) @(posedge clk);
        if (sb.size() > 0) begin
            failed++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
